xbar_out_ctrl: RTL

XBAR_OUT_CTRL -- requirements
Module: xbar_out_ctrl

---
 rtl/xbar_out_ctrl_if.sv | 36 +++
 rtl/xbar_out_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/xbar_out_ctrl_if.sv
// Crossbar output-port bundle: the scheduler grant/stall pair, per-port input
// streams and the single registered output stream with its error flags.
interface xbar_out_ctrl_if #(
  parameter int NUM_PORT = 4,
  parameter int DATA_W   = 32
);
  localparam int SRC_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  logic [NUM_PORT-1:0]        grant;
  logic                       stall;
  logic [NUM_PORT-1:0]        in_valid;
  logic [NUM_PORT*DATA_W-1:0] in_data;
  logic [NUM_PORT-1:0]        in_eop;
  logic [NUM_PORT-1:0]        in_ready;
  logic                       out_valid;
  logic [DATA_W-1:0]          out_data;
  logic                       out_sop;
  logic                       out_eop;
  logic [SRC_W-1:0]           out_src;
  logic                       out_ready;
  logic                       err_len;
  logic                       err_grant;

  // The output controller drives the stall, ready and output side.
  modport master (
    input  grant, in_valid, in_data, in_eop, out_ready,
    output stall, in_ready, out_valid, out_data, out_sop, out_eop, out_src,
           err_len, err_grant
  );

  modport slave (
    output grant, in_valid, in_data, in_eop, out_ready,
    input  stall, in_ready, out_valid, out_data, out_sop, out_eop, out_src,
           err_len, err_grant
  );
endinterface

// File: rtl/xbar_out_ctrl.sv
// Crossbar output controller: takes one granted input port at a time, moves
// its packet word-by-word into a one-entry output register, cutting at MAX_BEATS.
module xbar_out_ctrl #(
  parameter int NUM_PORT  = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 64
) (
  input  logic            clk,
  input  logic            rst,
  xbar_out_ctrl_if.master bus_io
);
  localparam int SRC_W  = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [SRC_W-1:0]    sel_q, sel_d;
  logic                sop_pend_q, sop_pend_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;
  logic [SRC_W-1:0]    out_src_q, out_src_d;
  logic                err_len_q, err_len_d;
  logic                err_grant_q, err_grant_d;

  logic [DATA_W-1:0]   word_data [NUM_PORT];
  logic [SRC_W-1:0]    grant_idx;
  logic                grant_any, grant_multi;
  logic                slot_free, accept, forced, word_eop;

  generate
    for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_port
      assign word_data[gi] = bus_io.in_data[gi*DATA_W +: DATA_W];
      assign bus_io.in_ready[gi] = ~rst & (state_q == XFER) &
                                   (sel_q == SRC_W'(gi)) & slot_free;
    end
  endgenerate

  // Lowest set bit wins when the scheduler hands over a malformed grant.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      if (bus_io.grant[i]) grant_idx = SRC_W'(i);
    end
  end

  assign grant_any   = |bus_io.grant;
  assign grant_multi = |(bus_io.grant & (bus_io.grant - NUM_PORT'(1)));
  assign slot_free   = ~out_valid_q | bus_io.out_ready;
  assign accept      = |(bus_io.in_valid & bus_io.in_ready);
  assign forced      = (beat_q == LAST_BEAT);
  assign word_eop    = bus_io.in_eop[sel_q] | forced;

  assign bus_io.stall = rst | ~((state_q == IDLE) & grant_any);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sop_pend_d  = sop_pend_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_src_d   = out_src_q;
    err_len_d   = err_len_q;
    err_grant_d = err_grant_q;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          sel_d      = grant_idx;
          sop_pend_d = 1'b1;
          beat_d     = '0;
          state_d    = XFER;
          if (grant_multi) err_grant_d = 1'b1;
        end
      end
      XFER: begin
        if (accept) begin
          beat_d     = beat_q + 1'b1;
          sop_pend_d = 1'b0;
          if (word_eop) state_d = IDLE;
          if (forced && !bus_io.in_eop[sel_q]) err_len_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load and unload may coincide, which keeps a full word per cycle.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = word_data[sel_q];
      out_sop_d   = sop_pend_q;
      out_eop_d   = word_eop;
      out_src_d   = sel_q;
    end else if (bus_io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      sop_pend_q  <= 1'b0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_src_q   <= '0;
      err_len_q   <= 1'b0;
      err_grant_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sop_pend_q  <= sop_pend_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_src_q   <= out_src_d;
      err_len_q   <= err_len_d;
      err_grant_q <= err_grant_d;
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_sop   = out_sop_q;
  assign bus_io.out_eop   = out_eop_q;
  assign bus_io.out_src   = out_src_q;
  assign bus_io.err_len   = err_len_q;
  assign bus_io.err_grant = err_grant_q;
endmodule
